grf: RTL
========

# grf

General register file for the single-cycle MIPS core: 32 × 32-bit registers with two combinational read ports and one clocked write port. The write address is the destination register chosen by the write-register select upstream (rt, rd or $31), so this block is the write-side consumer of that selection. It also produces a registered one-cycle write trace and a retired-write counter, which the bench compares against the golden trace.

## Interface
Parameters:
- `BYPASS`, default 1; when 1, a read of the register being written this cycle returns `wd`.
- `CNT_W`, default 32; width of `wr_count`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `we` in 1: write enable from control.
- `a1` in 5: read address 1 (rs).
- `a2` in 5: read address 2 (rt).
- `wreg` in 5: write address (selected rt/rd/$31).
- `wd` in 32: write data.
- `pc` in 32: PC of the instruction currently in the cycle, used for trace only.
- `rd1` out 32: read data 1.
- `rd2` out 32: read data 2.
- `trace_valid` out 1: a write was committed on the previous edge.
- `trace_pc` out 32: PC of that write.
- `trace_reg` out 5: register number of that write.
- `trace_data` out 32: value written.
- `wr_count` out CNT_W: number of committed writes since reset.

## Operation
- A write is accepted on a rising edge when `we`=1 and `wreg`≠0.
- An accepted write updates `regs[wreg]`<=`wd`, pulses the trace outputs and increments `wr_count`.
- A write with `wreg`=0 is dropped silently:
  - $0 stays 0.
  - No trace pulse.
  - No count increment.
- Reads are combinational.
  - `rd1` = 0 if `a1`=0.
  - Otherwise, if BYPASS=1 and the write is accepted and `wreg`==`a1`, `rd1` = `wd`.
  - Otherwise `rd1` = `regs[a1]`.
  - `rd2` is identical, using `a2`.
- BYPASS=0 means the old value is read until the edge.
- Both ports may read the same address, including the one being written. Both then return the same value.
- `wr_count` wraps from all-ones to 0 with no flag.
- The trace stage is a single register:
  - On an accepted write: `trace_valid`<=1 and capture `pc`, `wreg`, `wd`.
  - Otherwise: `trace_valid`<=0. The payload fields hold their last values.
- Reset while asserted:
  - All 32 registers clear to 0.
  - All trace outputs and `wr_count` clear to 0.
  - Writes are ignored.
  - Reads return 0 for every address. A pending `wd` is not bypassed while reset=1.
- Reset asserted mid-cycle clears state immediately, without waiting for an edge.
- After release, the first edge with an accepted write behaves normally.

## Timing
- Read latency 0: combinational from `a1`/`a2`/`regs`, plus `we`/`wreg`/`wd` when BYPASS=1.
- Write latency 1 edge: the new value is visible in `regs` after the edge at which it was accepted.
- Trace latency 1 edge:
  - `trace_valid` is high for exactly the cycle after each accepted write.
  - Back-to-back writes give consecutive high cycles, each carrying its own payload.
- `wr_count` updates on the same edge as the register write.
- Reset values: `rd1`=`rd2`=0, `trace_valid`=0, `trace_pc`=0, `trace_reg`=0, `trace_data`=0, `wr_count`=0.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_ZERO`=5'd0, `REG_RA`=5'd31, `NUM_REGS`=32.
  - The 5-bit register index typedef.
  - The write-register select encodings: 00 rt, 01 rd, 10 $31, 11 treated as rt.
- Natural sub-module `grf_trace`: the registered trace and counter stage, fed by an "accepted" strobe plus `pc`/`wreg`/`wd`.
- The storage array and read muxes stay in `grf`.

## Test plan
- Reset then read: pulse reset asynchronously between edges; read all 32 addresses -> all 0; `wr_count`=0; `trace_valid`=0.
- Basic write: `we`=1, `wreg`=8, `wd`=32'h1234_5678, `pc`=32'h3000 -> next cycle `rd1`(a1=8)=32'h1234_5678, `trace_valid`=1, `trace_reg`=8, `trace_pc`=32'h3000, `wr_count`=1.
- $0 protection: `we`=1, `wreg`=0, `wd`=32'hFFFF_FFFF -> `rd1`(a1=0)=0, `trace_valid`=0, `wr_count` unchanged.
- Bypass: regs[31]=5, then `we`=1, `wreg`=31, `wd`=9 with `a1`=`a2`=31 in the same cycle:
  - BYPASS=1 -> `rd1`=`rd2`=9 before the edge.
  - BYPASS=0 -> `rd1`=`rd2`=5 before the edge and 9 after it.
- Back-to-back writes: write $1=1 then $2=2 on consecutive edges -> `trace_valid` high for 2 cycles with `trace_reg` 1 then 2; `wr_count`=2.
- Reset mid-operation and wrap: with `CNT_W`=2:
  - Five accepted writes -> `wr_count` reads 1 (wrapped).
  - Assert reset mid-cycle -> `wr_count`, registers and trace clear immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register indices, register-file size and
// the write-register select encodings used ahead of the register file.
package mips_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        WSEL_RT     = 2'b00,
        WSEL_RD     = 2'b01,
        WSEL_RA     = 2'b10,
        WSEL_RT_ALT = 2'b11
    } wsel_e;

    // Destination register chosen upstream; the spare encoding falls back to rt.
    function automatic reg_idx_t sel_wreg(input wsel_e sel, input reg_idx_t rt, input reg_idx_t rd);
        case (sel)
            WSEL_RD: sel_wreg = rd;
            WSEL_RA: sel_wreg = REG_RA;
            default: sel_wreg = rt;
        endcase
    endfunction

endpackage

// File: rtl/grf_trace.sv
// Registered one-cycle write trace plus a wrapping count of committed writes.
module grf_trace
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accepted,
    input  logic [31:0]      pc,
    input  reg_idx_t         wreg,
    input  logic [31:0]      wd,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output reg_idx_t         trace_reg,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] wr_count
);

    logic             valid_reg;
    logic [31:0]      pc_reg;
    reg_idx_t         wreg_reg;
    logic [31:0]      data_reg;
    logic [CNT_W-1:0] count_reg;

    // Payload holds its last value when no write commits; only valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            wreg_reg  <= REG_ZERO;
            data_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= accepted;
            if (accepted) begin
                pc_reg    <= pc;
                wreg_reg  <= wreg;
                data_reg  <= wd;
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign trace_valid = valid_reg;
    assign trace_pc    = pc_reg;
    assign trace_reg   = wreg_reg;
    assign trace_data  = data_reg;
    assign wr_count    = count_reg;

endmodule

// File: rtl/grf.sv
// 32 x 32-bit general register file: two combinational read ports with optional
// same-cycle write bypass, one clocked write port, and a write trace stage.
module grf
    import mips_pkg::*;
#(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2,
    input  logic [4:0]       wreg,
    input  logic [31:0]      wd,
    input  logic [31:0]      pc,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_reg,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] wr_count
);

    logic [31:0] regs [NUM_REGS];
    logic        accepted;

    // Writes to $0 and writes while reset is held never commit.
    assign accepted = we && (wreg != REG_ZERO) && !reset;

    // $0 is never addressed by an accepted write, so it stays at its reset value.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    regs[gi] <= '0;
                end else if (accepted && (wreg == reg_idx_t'(gi))) begin
                    regs[gi] <= wd;
                end
            end
        end
    endgenerate

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!reset) begin
            if (a1 != REG_ZERO) begin
                rd1 = (BYPASS != 0 && accepted && wreg == a1) ? wd : regs[a1];
            end
            if (a2 != REG_ZERO) begin
                rd2 = (BYPASS != 0 && accepted && wreg == a2) ? wd : regs[a2];
            end
        end
    end

    grf_trace #(
        .CNT_W(CNT_W)
    ) u_trace (
        .clk        (clk),
        .reset      (reset),
        .accepted   (accepted),
        .pc         (pc),
        .wreg       (wreg),
        .wd         (wd),
        .trace_valid(trace_valid),
        .trace_pc   (trace_pc),
        .trace_reg  (trace_reg),
        .trace_data (trace_data),
        .wr_count   (wr_count)
    );

endmodule
